// File: rtl/ibex_rf_wipe_ctrl.sv
// Secure-wipe sequencer for the register file write port.
// An internal walker overwrites every architectural register, optionally with an LFSR pass
// followed by a constant pass. Core writes always own the port; the walker stalls under them.
module ibex_rf_wipe_ctrl #(
  parameter bit                   RV32E             = 1'b0,
  // Must be 32 when RandomPass is set; the LFSR is 32 bits wide.
  parameter int unsigned          DataWidth         = 32,
  parameter bit                   DummyInstructions = 1'b0,
  parameter bit                   RandomPass        = 1'b1,
  parameter logic [31:0]          LfsrSeed          = 32'hACE12468,
  parameter logic [DataWidth-1:0] WordZeroVal       = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,

  // Wipe control
  input  logic                 wipe_req_i,
  output logic                 wipe_busy_o,
  output logic                 wipe_done_o,

  // LFSR reseed
  input  logic                 lfsr_seed_en_i,
  input  logic [31:0]          lfsr_seed_i,

  // Core write port
  input  logic                 core_we_i,
  input  logic [4:0]           core_waddr_i,
  input  logic [DataWidth-1:0] core_wdata_i,
  input  logic                 core_dummy_wb_i,

  // Register file write port
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_dummy_wb_o
);

  localparam int unsigned NumWords  = RV32E ? 16 : 32;
  localparam logic [4:0]  StartAddr = DummyInstructions ? 5'd0 : 5'd1;
  localparam logic [4:0]  LastAddr  = 5'(NumWords - 1);
  localparam logic [31:0] LfsrTaps  = 32'h80200003;

  typedef enum logic [1:0] {
    StIdle,
    StPassRnd,
    StPassZero
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic        done_q, done_d;

  logic                 busy;
  logic                 wipe_we;
  logic                 at_last;
  logic [31:0]          lfsr_next;
  logic [DataWidth-1:0] rnd_data;

  assign busy    = (state_q != StIdle);
  // A wipe write is only issued on cycles the core leaves the port free.
  assign wipe_we = busy & ~core_we_i;
  assign at_last = (addr_q == LastAddr);

  assign lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrTaps : 32'h0);
  assign rnd_data  = DataWidth'(lfsr_q);

  // Walker state, address counter and done pulse register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      addr_q  <= StartAddr;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  // LFSR register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Next-state: pass sequencing and address walk; everything holds while the core writes.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (wipe_req_i) begin
          state_d = RandomPass ? StPassRnd : StPassZero;
          addr_d  = StartAddr;
        end
      end

      StPassRnd: begin
        if (wipe_we) begin
          if (at_last) begin
            state_d = StPassZero;
            addr_d  = StartAddr;
          end else begin
            addr_d = addr_q + 5'd1;
          end
        end
      end

      StPassZero: begin
        if (wipe_we) begin
          if (at_last) begin
            state_d = StIdle;
            addr_d  = StartAddr;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q + 5'd1;
          end
        end
      end

      default: begin
        state_d = StIdle;
        addr_d  = StartAddr;
      end
    endcase
  end

  // LFSR next value: reseed wins over advance; a zero seed would lock up, so use the default.
  always_comb begin
    lfsr_d = lfsr_q;
    if (lfsr_seed_en_i) begin
      lfsr_d = (lfsr_seed_i == 32'h0) ? LfsrSeed : lfsr_seed_i;
    end else if (wipe_we && (state_q == StPassRnd)) begin
      lfsr_d = lfsr_next;
    end
  end

  // Write port mux: core first, then the walker, otherwise no write.
  always_comb begin
    rf_we_o       = 1'b0;
    rf_waddr_o    = core_waddr_i;
    rf_wdata_o    = core_wdata_i;
    rf_dummy_wb_o = core_dummy_wb_i;

    if (core_we_i) begin
      rf_we_o = 1'b1;
    end else if (busy) begin
      rf_we_o       = 1'b1;
      rf_waddr_o    = addr_q;
      rf_wdata_o    = (state_q == StPassRnd) ? rnd_data : WordZeroVal;
      rf_dummy_wb_o = (addr_q == 5'd0);
    end
  end

  assign wipe_busy_o = busy;
  assign wipe_done_o = done_q;

  // The done pulse always lands in an idle cycle.
  done_not_busy_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    wipe_done_o |-> !wipe_busy_o);

  // A busy walker always owns the port when the core is quiet.
  busy_writes_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (wipe_busy_o && !core_we_i) |-> rf_we_o);

endmodule

// File: tb/tb_ibex_rf_wipe_ctrl.sv
// Bench for ibex_rf_wipe_ctrl: three configurations share one stimulus stream and are compared
// each cycle against a model that precomputes the full list of wipe writes at request time.
module tb_ibex_rf_wipe_ctrl;

  localparam int          NI          = 3;
  localparam logic [31:0] LfsrSeedDef = 32'hACE12468;

  logic        clk;
  logic        rst_n;
  logic        wipe_req;
  logic        seed_en;
  logic [31:0] seed;
  logic        core_we;
  logic [4:0]  core_waddr;
  logic [31:0] core_wdata;
  logic        core_dummy;

  logic        busy     [NI];
  logic        done     [NI];
  logic        rf_we    [NI];
  logic [4:0]  rf_waddr [NI];
  logic [31:0] rf_wdata [NI];
  logic        rf_dummy [NI];

  int checks   = 0;
  int failures = 0;

  // Instance 0: zero pass only, 32 words from R1.
  ibex_rf_wipe_ctrl #(
    .RV32E(1'b0), .DataWidth(32), .DummyInstructions(1'b0), .RandomPass(1'b0),
    .LfsrSeed(32'hACE12468), .WordZeroVal(32'h0)
  ) u_zero (
    .clk_i(clk), .rst_ni(rst_n), .wipe_req_i(wipe_req), .wipe_busy_o(busy[0]),
    .wipe_done_o(done[0]), .lfsr_seed_en_i(seed_en), .lfsr_seed_i(seed),
    .core_we_i(core_we), .core_waddr_i(core_waddr), .core_wdata_i(core_wdata),
    .core_dummy_wb_i(core_dummy), .rf_we_o(rf_we[0]), .rf_waddr_o(rf_waddr[0]),
    .rf_wdata_o(rf_wdata[0]), .rf_dummy_wb_o(rf_dummy[0])
  );

  // Instance 1: LFSR pass then zero pass, 32 words from R1.
  ibex_rf_wipe_ctrl #(
    .RV32E(1'b0), .DataWidth(32), .DummyInstructions(1'b0), .RandomPass(1'b1),
    .LfsrSeed(32'hACE12468), .WordZeroVal(32'h0)
  ) u_rnd (
    .clk_i(clk), .rst_ni(rst_n), .wipe_req_i(wipe_req), .wipe_busy_o(busy[1]),
    .wipe_done_o(done[1]), .lfsr_seed_en_i(seed_en), .lfsr_seed_i(seed),
    .core_we_i(core_we), .core_waddr_i(core_waddr), .core_wdata_i(core_wdata),
    .core_dummy_wb_i(core_dummy), .rf_we_o(rf_we[1]), .rf_waddr_o(rf_waddr[1]),
    .rf_wdata_o(rf_wdata[1]), .rf_dummy_wb_o(rf_dummy[1])
  );

  // Instance 2: RV32E with dummy R0, zero pass only, 16 words from R0.
  ibex_rf_wipe_ctrl #(
    .RV32E(1'b1), .DataWidth(32), .DummyInstructions(1'b1), .RandomPass(1'b0),
    .LfsrSeed(32'hACE12468), .WordZeroVal(32'h0)
  ) u_e (
    .clk_i(clk), .rst_ni(rst_n), .wipe_req_i(wipe_req), .wipe_busy_o(busy[2]),
    .wipe_done_o(done[2]), .lfsr_seed_en_i(seed_en), .lfsr_seed_i(seed),
    .core_we_i(core_we), .core_waddr_i(core_waddr), .core_wdata_i(core_wdata),
    .core_dummy_wb_i(core_dummy), .rf_we_o(rf_we[2]), .rf_waddr_o(rf_waddr[2]),
    .rf_wdata_o(rf_wdata[2]), .rf_dummy_wb_o(rf_dummy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a pending list of wipe writes per instance.
  bit          m_busy [NI];
  bit          m_done [NI];
  int          m_idx  [NI];
  int          m_len  [NI];
  logic [31:0] m_lfsr [NI];
  logic [4:0]  m_addr [NI][64];
  logic [31:0] m_data [NI][64];

  function automatic int words_of(int i);
    return (i == 2) ? 16 : 32;
  endfunction

  function automatic int start_of(int i);
    return (i == 2) ? 0 : 1;
  endfunction

  function automatic bit rnd_of(int i);
    return (i == 1);
  endfunction

  function automatic logic [31:0] lfsr_step(logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  task automatic build(int i);
    int n = 0;
    if (rnd_of(i)) begin
      for (int a = start_of(i); a < words_of(i); a++) begin
        m_addr[i][n] = 5'(a);
        m_data[i][n] = m_lfsr[i];
        m_lfsr[i]    = lfsr_step(m_lfsr[i]);
        n++;
      end
    end
    for (int a = start_of(i); a < words_of(i); a++) begin
      m_addr[i][n] = 5'(a);
      m_data[i][n] = 32'h0;
      n++;
    end
    m_len[i]  = n;
    m_idx[i]  = 0;
    m_busy[i] = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_busy[i] = 1'b0;
      m_done[i] = 1'b0;
      m_idx[i]  = 0;
      m_len[i]  = 0;
      m_lfsr[i] = LfsrSeedDef;
    end
  endtask

  // {busy, done, we, addr, data, dummy}; write fields are zero when no write is expected.
  function automatic logic [40:0] exp_vec(int i);
    logic [40:0] v;
    v[40] = m_busy[i];
    v[39] = m_done[i];
    if (core_we) begin
      v[38:0] = {1'b1, core_waddr, core_wdata, core_dummy};
    end else if (m_busy[i]) begin
      v[38:0] = {1'b1, m_addr[i][m_idx[i]], m_data[i][m_idx[i]], (m_addr[i][m_idx[i]] == 5'd0)};
    end else begin
      v[38:0] = '0;
    end
    return v;
  endfunction

  function automatic logic [40:0] act_vec(int i);
    logic [40:0] v;
    v[40]   = busy[i];
    v[39]   = done[i];
    v[38:0] = rf_we[i] ? {1'b1, rf_waddr[i], rf_wdata[i], rf_dummy[i]} : 39'h0;
    return v;
  endfunction

  function automatic bit any_busy();
    bit b = 1'b0;
    for (int i = 0; i < NI; i++) b |= m_busy[i] | (busy[i] === 1'b1);
    return b;
  endfunction

  // Advance the model across the next rising edge, then move the clock there.
  task automatic step();
    for (int i = 0; i < NI; i++) begin
      bit was_busy = m_busy[i];
      m_done[i] = 1'b0;
      if (!rst_n) begin
        m_busy[i] = 1'b0;
        m_lfsr[i] = LfsrSeedDef;
      end else begin
        if (seed_en) m_lfsr[i] = (seed == 32'h0) ? LfsrSeedDef : seed;
        if (was_busy && !core_we) begin
          m_idx[i]++;
          if (m_idx[i] == m_len[i]) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
          end
        end else if (!was_busy && wipe_req) begin
          build(i);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_core(int pct);
    core_we    = ($urandom_range(0, 99) < pct);
    core_waddr = 5'($urandom);
    core_wdata = $urandom;
    core_dummy = 1'($urandom);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      rand_core(50);
      #1;
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          failures++;
          $display("FAIL reset inst=%0d got=%h exp=%h", i, act_vec(i), exp_vec(i));
        end
      end
      step();
    end
    core_we = 1'b0;
    rst_n   = 1'b1;
    step();
  endtask

  task automatic test_zero_and_rnd_pass();
    int cnt_a = 0, busy_a = 0, done_a = 0, done_b = 0, cnt_c = 0, dum_c = 0;
    logic [31:0] b_first = '0, b_second = '0;
    seed_en = 1'b1;
    seed    = 32'h00000001;
    step();
    seed_en  = 1'b0;
    wipe_req = 1'b1;
    step();
    wipe_req = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          failures++;
          $display("FAIL pass c=%0d inst=%0d got=%h exp=%h", c, i, act_vec(i), exp_vec(i));
        end
      end
      if (rf_we[0] === 1'b1) cnt_a++;
      if (busy[0] === 1'b1) busy_a++;
      if (done[0] === 1'b1 && done_a == 0) done_a = c;
      if (done[1] === 1'b1 && done_b == 0) done_b = c;
      if (c == 1) b_first = rf_wdata[1];
      if (c == 2) b_second = rf_wdata[1];
      if (rf_we[2] === 1'b1) cnt_c++;
      if (rf_we[2] === 1'b1 && rf_dummy[2] === 1'b1) dum_c++;
      step();
    end
    checks += 8;
    if (cnt_a != 31) begin failures++; $display("FAIL zero_writes got=%0d exp=31", cnt_a); end
    if (busy_a != 31) begin failures++; $display("FAIL zero_busy got=%0d exp=31", busy_a); end
    if (done_a != 32) begin failures++; $display("FAIL zero_done got=%0d exp=32", done_a); end
    if (done_b != 63) begin failures++; $display("FAIL rnd_done got=%0d exp=63", done_b); end
    if (b_first !== 32'h1) begin
      failures++; $display("FAIL rnd_first got=%h exp=00000001", b_first);
    end
    if (b_second !== 32'h80200003) begin
      failures++; $display("FAIL rnd_second got=%h exp=80200003", b_second);
    end
    if (cnt_c != 16) begin failures++; $display("FAIL e_writes got=%0d exp=16", cnt_c); end
    if (dum_c != 1) begin failures++; $display("FAIL e_dummy got=%0d exp=1", dum_c); end
  endtask

  task automatic test_core_collision();
    int budget = 0;
    seed_en = 1'b1;
    seed    = $urandom | 32'h1;
    step();
    seed_en  = 1'b0;
    wipe_req = 1'b1;
    step();
    wipe_req = 1'b0;
    while (m_idx[0] != 6 && budget < 20) begin
      budget++;
      step();
    end
    core_we    = 1'b1;
    core_waddr = 5'd5;
    core_wdata = 32'hDEADBEEF;
    core_dummy = 1'b0;
    #1;
    checks++;
    if (rf_waddr[0] !== 5'd5 || rf_wdata[0] !== 32'hDEADBEEF || rf_we[0] !== 1'b1) begin
      failures++;
      $display("FAIL collide_core got=%0d/%h exp=5/deadbeef", rf_waddr[0], rf_wdata[0]);
    end
    step();
    core_we = 1'b0;
    #1;
    checks++;
    if (rf_waddr[0] !== 5'd7 || rf_we[0] !== 1'b1) begin
      failures++;
      $display("FAIL collide_resume got=%0d exp=7", rf_waddr[0]);
    end
    budget = 0;
    while (any_busy() && budget < 500) begin
      rand_core(25);
      #1;
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          failures++;
          $display("FAIL collide inst=%0d got=%h exp=%h", i, act_vec(i), exp_vec(i));
        end
      end
      step();
      budget++;
    end
    core_we = 1'b0;
    if (budget >= 500) begin
      checks++; failures++; $display("FAIL collide_timeout got=busy exp=idle");
    end
  endtask

  task automatic test_reset_midwipe();
    int budget = 0;
    wipe_req = 1'b1;
    step();
    wipe_req = 1'b0;
    while (m_idx[0] != 9 && budget < 20) begin
      budget++;
      step();
    end
    checks++;
    if (rf_waddr[0] !== 5'd10) begin
      failures++; $display("FAIL midwipe_addr got=%0d exp=10", rf_waddr[0]);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (busy[i] !== 1'b0 || done[i] !== 1'b0 || act_vec(i) !== exp_vec(i)) begin
          failures++;
          $display("FAIL midwipe_rst inst=%0d got=%h exp=%h", i, act_vec(i), exp_vec(i));
        end
      end
      step();
    end
    rst_n = 1'b1;
    step();
    wipe_req = 1'b1;
    step();
    wipe_req = 1'b0;
    checks += 3;
    if (rf_waddr[0] !== 5'd1) begin
      failures++; $display("FAIL restart_a got=%0d exp=1", rf_waddr[0]);
    end
    if (rf_waddr[2] !== 5'd0) begin
      failures++; $display("FAIL restart_e got=%0d exp=0", rf_waddr[2]);
    end
    if (rf_wdata[1] !== LfsrSeedDef) begin
      failures++; $display("FAIL restart_lfsr got=%h exp=%h", rf_wdata[1], LfsrSeedDef);
    end
    budget = 0;
    while (any_busy() && budget < 200) begin
      #1;
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          failures++;
          $display("FAIL restart inst=%0d got=%h exp=%h", i, act_vec(i), exp_vec(i));
        end
      end
      step();
      budget++;
    end
    if (budget >= 200) begin
      checks++; failures++; $display("FAIL restart_timeout got=busy exp=idle");
    end
  endtask

  task automatic test_seed_zero();
    int done_b = 0, budget = 0;
    seed_en = 1'b1;
    seed    = 32'h0;
    step();
    seed_en  = 1'b0;
    wipe_req = 1'b1;
    step();
    for (int c = 1; budget < 300 && (c <= 63 || any_busy()); c++) begin
      wipe_req = (c < 62) && ($urandom_range(0, 3) == 0);
      #1;
      if (c == 1) begin
        checks++;
        if (rf_wdata[1] !== 32'hACE12468) begin
          failures++; $display("FAIL seed_zero got=%h exp=ace12468", rf_wdata[1]);
        end
      end
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          failures++;
          $display("FAIL seed inst=%0d c=%0d got=%h exp=%h", i, c, act_vec(i), exp_vec(i));
        end
      end
      if (done[1] === 1'b1 && done_b == 0) done_b = c;
      step();
      budget++;
    end
    wipe_req = 1'b0;
    checks++;
    if (done_b != 63) begin failures++; $display("FAIL busy_req_done got=%0d exp=63", done_b); end
  endtask

  task automatic test_back_to_back();
    int budget = 0;
    wipe_req = 1'b1;
    for (int c = 0; c < 200; c++) begin
      rand_core(20);
      #1;
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          failures++;
          $display("FAIL b2b inst=%0d c=%0d got=%h exp=%h", i, c, act_vec(i), exp_vec(i));
        end
      end
      step();
    end
    wipe_req = 1'b0;
    while (any_busy() && budget < 300) begin
      rand_core(20);
      #1;
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          failures++;
          $display("FAIL b2b_drain inst=%0d got=%h exp=%h", i, act_vec(i), exp_vec(i));
        end
      end
      step();
      budget++;
    end
    core_we = 1'b0;
    if (budget >= 300) begin
      checks++; failures++; $display("FAIL b2b_timeout got=busy exp=idle");
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    wipe_req   = 1'b0;
    seed_en    = 1'b0;
    seed       = 32'h0;
    core_we    = 1'b0;
    core_waddr = 5'd0;
    core_wdata = 32'h0;
    core_dummy = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_zero_and_rnd_pass();
    test_core_collision();
    test_reset_midwipe();
    test_seed_zero();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
